// File: rtl/card_guess_scorer.sv
// card_guess_scorer: deals a card, takes a guess, scores suit/rank hits.
// Ports: clk/rst, start, card handshake, guess, display and score outputs.
module card_guess_scorer #(
  parameter int unsigned REVEAL_CYCLES = 'd50_000_000,
  parameter int unsigned ROUND_LIMIT   = 'd52,
  parameter int unsigned MAX_SCORE     = 'd99
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       card_valid_in,
  input  logic [1:0] card_suit_in,
  input  logic [3:0] card_rank_in,
  output logic       card_req_out,
  input  logic       guess_valid_in,
  input  logic [1:0] guess_suit_in,
  input  logic [3:0] guess_rank_in,
  output logic [1:0] suit_out,
  output logic [3:0] rank_out,
  output logic [6:0] suit_score_out,
  output logic [6:0] rank_score_out,
  output logic       reveal_out,
  output logic       suit_hit_out,
  output logic       rank_hit_out,
  output logic       game_over_out
);

  localparam int unsigned TW = $clog2(REVEAL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SCORE, S_REVEAL, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]    card_suit_q, card_suit_d;
  logic [3:0]    card_rank_q, card_rank_d;
  logic [1:0]    gsuit_q, gsuit_d;
  logic [3:0]    grank_q, grank_d;
  logic [1:0]    suit_q, suit_d;
  logic [3:0]    rank_q, rank_d;
  logic [6:0]    sscore_q, sscore_d;
  logic [6:0]    rscore_q, rscore_d;
  logic [5:0]    round_q, round_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hit_s_q, hit_s_d;
  logic          hit_r_q, hit_r_d;
  logic          req_q, req_d;
  logic          reveal_q, reveal_d;
  logic          over_q, over_d;

  function automatic logic legal_rank(input logic [3:0] r);
    return (r != 4'd0) && (r <= 4'd13);
  endfunction

  // start_in wins over any handshake in the same cycle
  logic card_ok, guess_ok, hit_s, hit_r;
  assign card_ok  = req_q && card_valid_in
                 && legal_rank(card_rank_in) && !start_in;
  assign guess_ok = (state_q == S_WAIT) && guess_valid_in
                 && legal_rank(guess_rank_in) && !start_in;
  assign hit_s    = (gsuit_q == card_suit_q);
  assign hit_r    = (grank_q == card_rank_q);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_in) begin
      state_d = S_REQ;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_REQ:    if (card_ok) state_d = S_WAIT;
        S_WAIT:   if (guess_ok) state_d = S_SCORE;
        S_SCORE:  state_d = S_REVEAL;
        S_REVEAL: begin
          if (timer_q == '0)
            state_d = (round_q == 6'(ROUND_LIMIT)) ? S_DONE : S_REQ;
        end
        S_DONE:   state_d = S_DONE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    card_suit_d = card_suit_q;
    card_rank_d = card_rank_q;
    gsuit_d     = gsuit_q;
    grank_d     = grank_q;
    suit_d      = suit_q;
    rank_d      = rank_q;
    sscore_d    = sscore_q;
    rscore_d    = rscore_q;
    round_d     = round_q;
    timer_d     = timer_q;
    hit_s_d     = hit_s_q;
    hit_r_d     = hit_r_q;
    unique case (state_q)
      S_REQ: begin
        if (card_ok) begin
          card_suit_d = card_suit_in;
          card_rank_d = card_rank_in;
        end
      end
      S_WAIT: begin
        suit_d = guess_suit_in;
        rank_d = guess_rank_in;
        if (guess_ok) begin
          gsuit_d = guess_suit_in;
          grank_d = guess_rank_in;
        end
      end
      S_SCORE: begin
        hit_s_d = hit_s;
        hit_r_d = hit_r;
        if (hit_s && sscore_q < 7'(MAX_SCORE)) sscore_d = sscore_q + 7'd1;
        if (hit_r && rscore_q < 7'(MAX_SCORE)) rscore_d = rscore_q + 7'd1;
        round_d = round_q + 6'd1;
        timer_d = TW'(REVEAL_CYCLES - 1);
        suit_d  = card_suit_q;
        rank_d  = card_rank_q;
      end
      S_REVEAL: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          hit_s_d = 1'b0;
          hit_r_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (start_in) begin
      sscore_d = '0;
      rscore_d = '0;
      round_d  = '0;
      hit_s_d  = 1'b0;
      hit_r_d  = 1'b0;
    end
    // status flags are registered copies of the upcoming state
    req_d    = (state_d == S_REQ);
    reveal_d = (state_d == S_REVEAL);
    over_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      card_suit_q <= '0;
      card_rank_q <= '0;
      gsuit_q     <= '0;
      grank_q     <= '0;
      suit_q      <= '0;
      rank_q      <= '0;
      sscore_q    <= '0;
      rscore_q    <= '0;
      round_q     <= '0;
      timer_q     <= '0;
      hit_s_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      req_q       <= 1'b0;
      reveal_q    <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      card_suit_q <= card_suit_d;
      card_rank_q <= card_rank_d;
      gsuit_q     <= gsuit_d;
      grank_q     <= grank_d;
      suit_q      <= suit_d;
      rank_q      <= rank_d;
      sscore_q    <= sscore_d;
      rscore_q    <= rscore_d;
      round_q     <= round_d;
      timer_q     <= timer_d;
      hit_s_q     <= hit_s_d;
      hit_r_q     <= hit_r_d;
      req_q       <= req_d;
      reveal_q    <= reveal_d;
      over_q      <= over_d;
    end
  end

  assign card_req_out   = req_q;
  assign suit_out       = suit_q;
  assign rank_out       = rank_q;
  assign suit_score_out = sscore_q;
  assign rank_score_out = rscore_q;
  assign reveal_out     = reveal_q;
  assign suit_hit_out   = hit_s_q;
  assign rank_hit_out   = hit_r_q;
  assign game_over_out  = over_q;

endmodule
